alarm_ctrl: RTL and testbench

//  Sequences the alarm speaker: detects alarm time against the running BCD clock and rings.

---
 rtl/alarm_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_alarm_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ctrl.sv
// -----------------------------------------------------------------------------
// alarm_ctrl
//   Alarm speaker sequencer. Compares the running BCD time against the alarm
//   time on each 1 Hz tick. On a match it rings, with an on/off beep cadence.
//   The user can snooze or stop the alarm. The ring also times out on its own.
//
//   States: IDLE -> RING on trigger. RING -> SNOOZE on snooze_btn.
//   SNOOZE -> RING after SNOOZE_S ticks. RING -> IDLE on stop, on disarm, or
//   after RING_TIMEOUT_S ticks.
//
// Ports
//   clk, rst_n              system clock, async active-low reset
//   sec_tick                1 Hz strobe; the cur_* digits are valid in that cycle
//   cur_{hr,min,sec}_{t,o}  current time, BCD tens/ones
//   alm_{hr,min}_{t,o}      alarm time, BCD tens/ones
//   alm_en                  alarm armed (level)
//   snooze_btn, stop_btn    one-cycle debounced button pulses
//   tone_en                 enables the speaker tone generator (registered)
//   ringing, snoozing       state flags (registered)
// -----------------------------------------------------------------------------
module alarm_ctrl #(
  parameter int unsigned CADENCE_CYC    = 50_000_000,
  parameter int unsigned SNOOZE_S       = 540,
  parameter int unsigned RING_TIMEOUT_S = 300
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic [1:0] cur_hr_t,
  input  logic [3:0] cur_hr_o,
  input  logic [2:0] cur_min_t,
  input  logic [3:0] cur_min_o,
  input  logic [2:0] cur_sec_t,
  input  logic [3:0] cur_sec_o,
  input  logic [1:0] alm_hr_t,
  input  logic [3:0] alm_hr_o,
  input  logic [2:0] alm_min_t,
  input  logic [3:0] alm_min_o,
  input  logic       alm_en,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       tone_en,
  output logic       ringing,
  output logic       snoozing
);

  localparam int unsigned SEC_MAX = (SNOOZE_S > RING_TIMEOUT_S) ? SNOOZE_S : RING_TIMEOUT_S;
  localparam int unsigned SEC_W   = $clog2(SEC_MAX + 1);
  // A one-cycle cadence would need a 0-bit counter, so keep at least one bit.
  localparam int unsigned CAD_W   = (CADENCE_CYC > 1) ? $clog2(CADENCE_CYC) : 1;

  localparam logic [CAD_W-1:0] CAD_LAST = CAD_W'(CADENCE_CYC - 1);
  localparam logic [SEC_W-1:0] RING_LIM = SEC_W'(RING_TIMEOUT_S);
  localparam logic [SEC_W-1:0] SNZ_LIM  = SEC_W'(SNOOZE_S);
  localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(1);
  localparam logic [CAD_W-1:0] CAD_ONE  = CAD_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RING    = 2'd1,
    SNOOZE  = 2'd2,
    ILLEGAL = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CAD_W-1:0] cad_q, cad_d;
  logic             phase_q, phase_d;
  logic [SEC_W-1:0] ring_sec_q, ring_sec_d;
  logic [SEC_W-1:0] snz_sec_q, snz_sec_d;
  logic             tone_en_q, ringing_q, snoozing_q;

  logic             time_match;
  logic             trigger;
  logic [SEC_W-1:0] ring_inc;
  logic [SEC_W-1:0] snz_inc;
  logic             entering;

  // The alarm fires only on the :00 second. A stop therefore cannot lead to
  // a re-trigger later in the same minute.
  assign time_match = (cur_hr_t  == alm_hr_t)  && (cur_hr_o  == alm_hr_o) &&
                      (cur_min_t == alm_min_t) && (cur_min_o == alm_min_o);
  assign trigger    = sec_tick && alm_en && time_match &&
                      (cur_sec_t == 3'd0) && (cur_sec_o == 4'd0);

  // These counters are compared before they are stored, so the stored value
  // tops out at limit-1. The incremented value never exceeds the limit, so
  // it cannot wrap.
  assign ring_inc = ring_sec_q + SEC_ONE;
  assign snz_inc  = snz_sec_q + SEC_ONE;

  // Next-state logic. Priority: stop > disarm > snooze > timeout/expiry > trigger.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!stop_btn && trigger) state_d = RING;
      end
      RING: begin
        if (stop_btn || !alm_en)                     state_d = IDLE;
        else if (snooze_btn)                         state_d = SNOOZE;
        else if (sec_tick && (ring_inc == RING_LIM)) state_d = IDLE;
      end
      SNOOZE: begin
        // snooze_btn is deliberately ignored while already snoozing.
        if (stop_btn || !alm_en)                    state_d = IDLE;
        else if (sec_tick && (snz_inc == SNZ_LIM))  state_d = RING;
      end
      default: state_d = IDLE;  // illegal encoding recovers to IDLE
    endcase
  end

  assign entering = (state_d != state_q);

  // Counter updates. They follow the state being entered or held.
  always_comb begin
    cad_d      = cad_q;
    phase_d    = phase_q;
    ring_sec_d = ring_sec_q;
    snz_sec_d  = snz_sec_q;
    unique case (state_d)
      RING: begin
        if (entering) begin
          // Every ring entry, first or after snooze, starts with a full ON beat.
          cad_d      = '0;
          phase_d    = 1'b1;
          ring_sec_d = '0;
          snz_sec_d  = '0;
        end else begin
          if (cad_q == CAD_LAST) begin
            cad_d   = '0;
            phase_d = ~phase_q;
          end else begin
            cad_d = cad_q + CAD_ONE;
          end
          if (sec_tick) ring_sec_d = ring_inc;
        end
      end
      SNOOZE: begin
        if (entering) begin
          cad_d      = '0;
          phase_d    = 1'b0;
          ring_sec_d = '0;
          snz_sec_d  = '0;
        end else if (sec_tick) begin
          snz_sec_d = snz_inc;
        end
      end
      default: begin
        cad_d      = '0;
        phase_d    = 1'b0;
        ring_sec_d = '0;
        snz_sec_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cad_q      <= '0;
      phase_q    <= 1'b0;
      ring_sec_q <= '0;
      snz_sec_q  <= '0;
      tone_en_q  <= 1'b0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cad_q      <= cad_d;
      phase_q    <= phase_d;
      ring_sec_q <= ring_sec_d;
      snz_sec_q  <= snz_sec_d;
      // Outputs are registered from next-state values. They therefore line
      // up with state_q in the same cycle.
      tone_en_q  <= (state_d == RING) && phase_d;
      ringing_q  <= (state_d == RING);
      snoozing_q <= (state_d == SNOOZE);
    end
  end

  assign tone_en  = tone_en_q;
  assign ringing  = ringing_q;
  assign snoozing = snoozing_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alarm_ctrl
//   Self-checking bench for alarm_ctrl. It uses CADENCE_CYC=4, SNOOZE_S=3,
//   RING_TIMEOUT_S=5, and the alarm is set to 07:30. Expected output vectors
//   {tone_en, ringing, snoozing} are queued as stimulus is driven. They are
//   popped and compared once the DUT has clocked that stimulus in.
// -----------------------------------------------------------------------------
module tb_alarm_ctrl;
  localparam int CAD = 4;
  localparam int SNZ = 3;
  localparam int TMO = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sec_tick = 1'b0;
  logic [1:0] cur_hr_t = '0;
  logic [3:0] cur_hr_o = '0;
  logic [2:0] cur_min_t = '0;
  logic [3:0] cur_min_o = '0;
  logic [2:0] cur_sec_t = '0;
  logic [3:0] cur_sec_o = '0;
  logic [1:0] alm_hr_t = 2'd0;
  logic [3:0] alm_hr_o = 4'd7;
  logic [2:0] alm_min_t = 3'd3;
  logic [3:0] alm_min_o = 4'd0;
  logic       alm_en = 1'b1;
  logic       snooze_btn = 1'b0;
  logic       stop_btn = 1'b0;
  logic       tone_en, ringing, snoozing;

  always #5 clk = ~clk;

  alarm_ctrl #(.CADENCE_CYC(CAD), .SNOOZE_S(SNZ), .RING_TIMEOUT_S(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick),
    .cur_hr_t(cur_hr_t), .cur_hr_o(cur_hr_o), .cur_min_t(cur_min_t),
    .cur_min_o(cur_min_o), .cur_sec_t(cur_sec_t), .cur_sec_o(cur_sec_o),
    .alm_hr_t(alm_hr_t), .alm_hr_o(alm_hr_o), .alm_min_t(alm_min_t),
    .alm_min_o(alm_min_o), .alm_en(alm_en), .snooze_btn(snooze_btn),
    .stop_btn(stop_btn), .tone_en(tone_en), .ringing(ringing), .snoozing(snoozing)
  );

  wire [2:0] obs = {tone_en, ringing, snoozing};

  logic [2:0] exp_q[$];
  logic [2:0] exp_v;
  int total = 0;
  int bad = 0;

  task automatic set_time(input logic [1:0] ht, input logic [3:0] ho,
                          input logic [2:0] mt, input logic [3:0] mo,
                          input logic [2:0] st, input logic [3:0] so);
    cur_hr_t = ht; cur_hr_o = ho; cur_min_t = mt;
    cur_min_o = mo; cur_sec_t = st; cur_sec_o = so;
  endtask

  // Advance one clock. Sampling happens 1 time unit after the edge, and the
  // one-cycle pulse inputs are dropped at that point.
  task automatic step();
    @(posedge clk); #1;
    sec_tick = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(3'b000);
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_async got=%b exp=%b", obs, exp_v); end
    step(); step();
    rst_n = 1'b1;
    exp_q.push_back(3'b000);
    step();
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_idle got=%b exp=%b", obs, exp_v); end
  endtask

  // Ring cadence: ON for CAD cycles, then OFF for CAD cycles, repeating.
  task automatic test_trigger();
    set_time(2'd0, 4'd7, 3'd3, 4'd0, 3'd0, 4'd0);
    sec_tick = 1'b1;
    for (int k = 0; k < 12; k++) begin
      exp_q.push_back({((k / CAD) % 2) == 0, 1'b1, 1'b0});
      step();
      if (k == 0) set_time(2'd0, 4'd7, 3'd3, 4'd0, 3'd0, 4'd1);
      exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL trigger k=%0d got=%b exp=%b", k, obs, exp_v); end
    end
    stop_btn = 1'b1;
    exp_q.push_back(3'b000);
    step();
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL trigger_stop got=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_no_trigger();
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: set_time(2'd0, 4'd7, 3'd3, 4'd0, 3'd0, 4'd1);
        1: begin set_time(2'd0, 4'd7, 3'd3, 4'd0, 3'd0, 4'd0); alm_en = 1'b0; end
        default: set_time(2'd0, 4'd7, 3'd3, 4'd1, 3'd0, 4'd0);
      endcase
      sec_tick = 1'b1;
      for (int k = 0; k < 2; k++) begin
        exp_q.push_back(3'b000);
        step();
        alm_en = 1'b1;
        set_time(2'd0, 4'd7, 3'd3, 4'd1, 3'd0, 4'd1);
        exp_v = exp_q.pop_front(); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL no_trig c=%0d k=%0d got=%b exp=%b", c, k, obs, exp_v); end
      end
    end
  endtask

  task automatic test_snooze();
    set_time(2'd0, 4'd7, 3'd3, 4'd0, 3'd0, 4'd0);
    sec_tick = 1'b1;
    exp_q.push_back(3'b110);
    step();
    set_time(2'd0, 4'd7, 3'd3, 4'd0, 3'd0, 4'd1);
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL snz_trig got=%b exp=%b", obs, exp_v); end
    exp_q.push_back(3'b110);
    step();
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL snz_ring got=%b exp=%b", obs, exp_v); end
    snooze_btn = 1'b1;
    exp_q.push_back(3'b001);
    step();
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL snz_enter got=%b exp=%b", obs, exp_v); end
    for (int t = 0; t < SNZ; t++) begin
      sec_tick = 1'b1;
      if (t == 1) snooze_btn = 1'b1;  // must be ignored in SNOOZE
      exp_q.push_back((t == SNZ - 1) ? 3'b110 : 3'b001);
      step();
      exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL snz_tick t=%0d got=%b exp=%b", t, obs, exp_v); end
      if (t < SNZ - 1) begin
        exp_q.push_back(3'b001);
        step();
        exp_v = exp_q.pop_front(); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL snz_gap t=%0d got=%b exp=%b", t, obs, exp_v); end
      end
    end
    // Re-ring must show a full ON beat, then OFF.
    for (int k = 1; k < 2 * CAD; k++) begin
      exp_q.push_back({((k / CAD) % 2) == 0, 1'b1, 1'b0});
      step();
      exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL snz_rering k=%0d got=%b exp=%b", k, obs, exp_v); end
    end
    snooze_btn = 1'b1;
    exp_q.push_back(3'b001);
    step();
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL snz_again got=%b exp=%b", obs, exp_v); end
    stop_btn = 1'b1;
    exp_q.push_back(3'b000);
    step();
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL snz_stop got=%b exp=%b", obs, exp_v); end
  endtask

  // The tick in the trigger cycle does not count. The 5th later tick ends the ring.
  task automatic test_timeout();
    set_time(2'd0, 4'd7, 3'd3, 4'd0, 3'd0, 4'd0);
    for (int k = 0; k <= TMO + 1; k++) begin
      sec_tick = (k <= TMO);
      if (k < TMO) exp_q.push_back({k < CAD, 1'b1, 1'b0});
      else         exp_q.push_back(3'b000);
      step();
      set_time(2'd0, 4'd7, 3'd3, 4'd0, 3'd0, 4'(k + 1));
      exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL timeout k=%0d got=%b exp=%b", k, obs, exp_v); end
    end
  endtask

  task automatic test_stop_priority();
    for (int c = 0; c < 3; c++) begin
      set_time(2'd0, 4'd7, 3'd3, 4'd0, 3'd0, 4'd0);
      sec_tick = 1'b1;
      exp_q.push_back(3'b110);
      step();
      set_time(2'd0, 4'd7, 3'd3, 4'd0, 3'd0, 4'd1);
      exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL prio_trig c=%0d got=%b exp=%b", c, obs, exp_v); end
      case (c)
        0: begin stop_btn = 1'b1; snooze_btn = 1'b1; end
        1: alm_en = 1'b0;
        default: begin
          snooze_btn = 1'b1;
          exp_q.push_back(3'b001);
          step();
          exp_v = exp_q.pop_front(); total++;
          if (obs !== exp_v) begin bad++; $display("FAIL prio_snz got=%b exp=%b", obs, exp_v); end
          stop_btn = 1'b1;
        end
      endcase
      exp_q.push_back(3'b000);
      step();
      alm_en = 1'b1;
      exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL prio_end c=%0d got=%b exp=%b", c, obs, exp_v); end
    end
    // A stop in the same cycle as the trigger keeps the block idle.
    set_time(2'd0, 4'd7, 3'd3, 4'd0, 3'd0, 4'd0);
    sec_tick = 1'b1; stop_btn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(3'b000);
      step();
      set_time(2'd0, 4'd7, 3'd3, 4'd0, 3'd0, 4'd1);
      exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL stop_trig k=%0d got=%b exp=%b", k, obs, exp_v); end
    end
  endtask

  task automatic test_async_reset();
    set_time(2'd0, 4'd7, 3'd3, 4'd0, 3'd0, 4'd0);
    sec_tick = 1'b1;
    exp_q.push_back(3'b110);
    step();
    set_time(2'd0, 4'd7, 3'd3, 4'd0, 3'd0, 4'd1);
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL ar_trig got=%b exp=%b", obs, exp_v); end
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(3'b000);
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL ar_async got=%b exp=%b", obs, exp_v); end
    step(); step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_time(2'd0, 4'd7, 3'd3, 4'd0, 3'd0, 4'(k + 2));
      sec_tick = 1'b1;
      exp_q.push_back(3'b000);
      step();
      exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL ar_idle k=%0d got=%b exp=%b", k, obs, exp_v); end
    end
    set_time(2'd0, 4'd7, 3'd3, 4'd0, 3'd0, 4'd0);
    sec_tick = 1'b1;
    exp_q.push_back(3'b110);
    step();
    set_time(2'd0, 4'd7, 3'd3, 4'd0, 3'd0, 4'd1);
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL ar_retrig got=%b exp=%b", obs, exp_v); end
    stop_btn = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_trigger();
    test_no_trigger();
    do_reset();
    test_snooze();
    do_reset();
    test_timeout();
    do_reset();
    test_stop_priority();
    do_reset();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
